// File: rtl/ps2_keycode_capture_if.sv
// Keycode PIO bundle between the PS/2 capture block and the HPS side:
// clear request in, scan-code history plus status pulses out.
interface ps2_keycode_capture_if;
   logic [31:0] keycode_reset;
   logic [31:0] keycode;
   logic        byte_valid;
   logic        frame_err;

   modport master (output keycode_reset, input keycode, byte_valid, frame_err);
   modport slave  (input keycode_reset, output keycode, byte_valid, frame_err);
endinterface

// File: rtl/ps2_keycode_capture.sv
// PS/2 keyboard receiver keeping a 4-byte scan-code history (newest in [7:0]).
// Optional build macro PS2_PARITY_CHECK_EN enables odd-parity rejection of frames.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a ps2_clk falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking the stop bit, then accept or flag an error
module ps2_keycode_capture #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic                 ps2_clk,
   input  logic                 ps2_dat,
   ps2_keycode_capture_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   prev_clk_s;
   logic                   clk_s;
   logic                   dat_s;
   logic                   fall;

   state_t      state, state_nxt;
   logic [2:0]  bit_cnt, bit_cnt_nxt;
   logic [7:0]  shift, shift_nxt;
   logic        par, par_nxt;
   logic [TW-1:0] to_cnt, to_nxt;
   logic        accept_q, accept_nxt;
   logic        err_q, err_nxt;
   logic        parity_ok;

   logic [31:0] keycode_r;
   logic        byte_valid_r;
   logic        frame_err_r;
   logic        kr_prev;
   logic        clr_rise;
   logic        unused_bits;

   assign clk_s = clk_sync[SYNC_STAGES-1];
   assign dat_s = dat_sync[SYNC_STAGES-1];
   assign fall  = prev_clk_s & ~clk_s;

`ifdef PS2_PARITY_CHECK_EN
   assign parity_ok = ^{shift, par};
`else
   assign parity_ok = 1'b1;
`endif

   assign unused_bits = ^{bus.keycode_reset[31:1], par};
   assign clr_rise    = bus.keycode_reset[0] & ~kr_prev;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         clk_sync   <= '1;
         dat_sync   <= '1;
         prev_clk_s <= 1'b1;
         state      <= IDLE;
         bit_cnt    <= '0;
         shift      <= '0;
         par        <= 1'b0;
         to_cnt     <= '0;
         accept_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync   <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
         prev_clk_s <= clk_s;
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shift      <= shift_nxt;
         par        <= par_nxt;
         to_cnt     <= to_nxt;
         accept_q   <= accept_nxt;
         err_q      <= err_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift;
      par_nxt     = par;
      to_nxt      = to_cnt;
      accept_nxt  = 1'b0;
      err_nxt     = 1'b0;
      if (fall) begin
         to_nxt = '0;
         case (state)
            IDLE: begin
               if (!dat_s) begin
                  state_nxt   = DATA;
                  bit_cnt_nxt = '0;
               end
            end
            DATA: begin
               shift_nxt   = {dat_s, shift[7:1]};
               bit_cnt_nxt = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nxt = PARITY;
            end
            PARITY: begin
               par_nxt   = dat_s;
               state_nxt = STOP;
            end
            STOP: begin
               state_nxt = IDLE;
               if (dat_s && parity_ok) accept_nxt = 1'b1;
               else                    err_nxt    = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end else if (state == IDLE) begin
         to_nxt = '0;
      end else if (to_cnt == TO_MAX) begin
         // Counter holds at the limit; it is cleared once the FSM is back in IDLE.
         state_nxt = IDLE;
         err_nxt   = 1'b1;
      end else begin
         to_nxt = to_cnt + TW'(1);
      end
   end

   // The shift register is stable here: the next frame cannot shift before another falling edge.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         keycode_r    <= '0;
         byte_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
         kr_prev      <= 1'b0;
      end else begin
         kr_prev      <= bus.keycode_reset[0];
         byte_valid_r <= accept_q;
         frame_err_r  <= err_q;
         if (accept_q)
            keycode_r <= clr_rise ? {24'h0, shift} : {keycode_r[23:0], shift};
         else if (clr_rise)
            keycode_r <= '0;
      end
   end

   assign bus.keycode    = keycode_r;
   assign bus.byte_valid = byte_valid_r;
   assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_keycode_capture.sv
// Scoreboard bench for ps2_keycode_capture: stimulus pushes expected events,
// a negedge monitor pops and compares on every byte_valid / frame_err pulse.
module tb_ps2_keycode_capture;

   localparam int SYNC    = 2;
   localparam int TIMEOUT = 200;
   localparam int HALF    = 6;

   typedef struct {
      logic        is_err;
      logic [31:0] kc;
   } exp_t;

   logic clk_clk = 1'b0;
   logic rst_n   = 1'b0;
   logic ps2_clk = 1'b1;
   logic ps2_dat = 1'b1;

   ps2_keycode_capture_if kbus ();

   ps2_keycode_capture #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (rst_n),
      .ps2_clk       (ps2_clk),
      .ps2_dat       (ps2_dat),
      .bus           (kbus)
   );

   always #5 clk_clk = ~clk_clk;

   int          checks   = 0;
   int          failures = 0;
   exp_t        sb[$];
   exp_t        e_mon;
   logic [31:0] exp_kc = 32'h0;

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic is_err, input logic [31:0] kc);
      exp_t e;
      e.is_err = is_err;
      e.kc     = kc;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   // nbits < 11 sends only a partial frame; lat_chk/clr_acc probe timing around the stop edge.
   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                             input int nbits, input logic lat_chk, input logic clr_acc);
      logic [10:0] bits;
      logic [31:0] old_kc;
      bits   = {stop, (~^d) ^ bad_par, d, 1'b0};
      old_kc = exp_kc;
      if (nbits == 11) begin
         if (stop && !(PAR_EN && bad_par)) begin
            exp_kc = clr_acc ? {24'h0, d} : {exp_kc[23:0], d};
            push_exp(1'b0, exp_kc);
         end else begin
            push_exp(1'b1, 32'h0);
         end
      end
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = bits[i];
         repeat (HALF) tick();
         ps2_clk = 1'b0;
         if (i == 10 && (lat_chk || clr_acc)) begin
            repeat (SYNC + 1) tick();
            chk("keycode_before_accept", kbus.keycode, old_kc);
            if (clr_acc) kbus.keycode_reset[0] = 1'b1;
            tick();
            chk("keycode_at_accept_latency", kbus.keycode, exp_kc);
            repeat (HALF - SYNC - 2) tick();
         end else begin
            repeat (HALF) tick();
         end
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
   endtask

   always @(negedge clk_clk) begin
      if (rst_n && (kbus.byte_valid || kbus.frame_err)) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output valid=%b err=%b keycode=%h required=no_event",
                     kbus.byte_valid, kbus.frame_err, kbus.keycode);
         end else begin
            e_mon = sb.pop_front();
            chk("event_is_err", {31'b0, kbus.frame_err}, {31'b0, e_mon.is_err});
            chk("event_is_valid", {31'b0, kbus.byte_valid}, {31'b0, ~e_mon.is_err});
            if (!e_mon.is_err) chk("keycode_on_valid", kbus.keycode, e_mon.kc);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      kbus.keycode_reset = 32'hDEAD_BEE0;
      rst_n = 1'b0;
      repeat (3) tick();
      chk("reset_keycode", kbus.keycode, 32'h0);
      chk("reset_byte_valid", {31'b0, kbus.byte_valid}, 32'h0);
      chk("reset_frame_err", {31'b0, kbus.frame_err}, 32'h0);
      rst_n = 1'b1;
      repeat (4) tick();

      // single frame with latency probe
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1, 1'b0);
      repeat (10) tick();

      // back-to-back frames
      send_frame(8'h11, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      send_frame(8'h33, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      send_frame(8'h44, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      send_frame(8'h55, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      repeat (10) tick();
      chk("keycode_after_burst", kbus.keycode, 32'h2233_4455);

      // bad parity, then bad stop bit
      send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
      send_frame(8'h3A, 1'b0, 1'b0, 11, 1'b0, 1'b0);
      repeat (10) tick();

      // timeout after start + 4 data bits
      push_exp(1'b1, 32'h0);
      send_frame(8'hFF, 1'b0, 1'b1, 5, 1'b0, 1'b0);
      repeat (TIMEOUT + 10) tick();
      send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      repeat (10) tick();
      chk("keycode_low_after_timeout", {24'h0, kbus.keycode[7:0]}, 32'h29);

      // clear, with bit 0 then held high across two accepts
      kbus.keycode_reset[0] = 1'b1;
      exp_kc = 32'h0;
      tick();
      chk("clear_first_rise", kbus.keycode, 32'h0);
      send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      repeat (10) tick();
      chk("hold_has_no_effect", kbus.keycode, 32'h0000_F01C);
      kbus.keycode_reset[0] = 1'b0;
      repeat (3) tick();
      kbus.keycode_reset[0] = 1'b1;
      exp_kc = 32'h0;
      tick();
      chk("clear_from_f01c", kbus.keycode, 32'h0);
      kbus.keycode_reset[0] = 1'b0;
      repeat (3) tick();

      // clear rising in the same cycle as an accept
      send_frame(8'h12, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0, 1'b1);
      repeat (10) tick();
      chk("keycode_after_clear_accept", kbus.keycode, 32'h0000_005A);
      kbus.keycode_reset[0] = 1'b0;
      repeat (3) tick();

      // reset in the middle of a frame
      send_frame(8'hA7, 1'b0, 1'b1, 4, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midreset_keycode", kbus.keycode, 32'h0);
      tick();
      chk("midreset_byte_valid", {31'b0, kbus.byte_valid}, 32'h0);
      chk("midreset_frame_err", {31'b0, kbus.frame_err}, 32'h0);
      rst_n = 1'b1;
      exp_kc = 32'h0;
      tick();
      chk("release_keycode", kbus.keycode, 32'h0);
      chk("release_byte_valid", {31'b0, kbus.byte_valid}, 32'h0);
      chk("release_frame_err", {31'b0, kbus.frame_err}, 32'h0);
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      repeat (10) tick();

      chk("scoreboard_empty", sb.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
